// File: rtl/grf_regfile.sv
// grf_regfile: 32-entry MIPS general register file with a committed-write counter and a simulation write trace.
// Optional build macro GRF_BYPASS_EN enables same-cycle write-to-read forwarding.
module grf_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD,
   input  logic              WE,
   input  logic [31:0]       PC,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic [CNT_W-1:0]  wcnt
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_r [DEPTH];
   logic [CNT_W-1:0]  wcnt_r;
   logic              commit_s;

   // Writes to $0 are dropped here, so entry 0 stays at its reset value forever.
   assign commit_s = WE && (A3 != {ADDR_W{1'b0}});
   assign wcnt     = wcnt_r;

   // Register array and write counter; the asynchronous reset clears everything without a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
         wcnt_r <= {CNT_W{1'b0}};
      end else begin
         if (commit_s) begin
            regs_r[A3] <= WD;
            wcnt_r     <= wcnt_r + CNT_W'(1);
         end
      end
   end

   // Read port 1: $0 wins over everything, then optional forwarding, then stored contents.
   always_comb begin
      RD1 = {DATA_W{1'b0}};
      if (A1 == {ADDR_W{1'b0}}) begin
         RD1 = {DATA_W{1'b0}};
`ifdef GRF_BYPASS_EN
      end else if (reset && WE && (A1 == A3)) begin
         RD1 = WD;
`endif
      end else begin
         RD1 = regs_r[A1];
      end
   end

   // Read port 2: same priority as port 1.
   always_comb begin
      RD2 = {DATA_W{1'b0}};
      if (A2 == {ADDR_W{1'b0}}) begin
         RD2 = {DATA_W{1'b0}};
`ifdef GRF_BYPASS_EN
      end else if (reset && WE && (A2 == A3)) begin
         RD2 = WD;
`endif
      end else begin
         RD2 = regs_r[A2];
      end
   end

`ifndef SYNTHESIS
   // Write trace for comparison with the reference simulator; $0 writes show a zero value.
   always @(posedge clk) begin
      if (reset && WE) begin
         $display("@%h: $%d <= %h", PC, A3, (A3 == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : WD);
      end
   end
`endif

endmodule

// File: tb/tb_grf_regfile.sv
// tb_grf_regfile: scoreboard bench for grf_regfile; a spec-level array model predicts reads and the write count.
// The counter is built 4 bits wide so wrap-around is reached quickly.
module tb_grf_regfile;

   localparam int CW = 4;

   logic        clk_s = 1'b0;
   logic        reset_s = 1'b0;
   logic [4:0]  a1_s = 5'd0, a2_s = 5'd0, a3_s = 5'd0;
   logic [31:0] wd_s = 32'd0, pc_s = 32'd0;
   logic        we_s = 1'b0;
   logic [31:0] rd1_s, rd2_s;
   logic [CW-1:0] wcnt_s;

   // reference model state
   logic [31:0] mem_m [32];
   int          wcnt_m = 0;

   // scoreboard queues
   logic [31:0] q_rd1 [$];
   logic [31:0] q_rd2 [$];
   int          q_wc  [$];
   string       q_nm  [$];
   event        sample_ev;

   int checks = 0;
   int failures = 0;

   grf_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
      .clk(clk_s), .reset(reset_s), .A1(a1_s), .A2(a2_s), .A3(a3_s),
      .WD(wd_s), .WE(we_s), .PC(pc_s), .RD1(rd1_s), .RD2(rd2_s), .wcnt(wcnt_s)
   );

   always #10 clk_s = ~clk_s;

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef GRF_BYPASS_EN
      if (reset_s && we_s && (a3_s != 5'd0) && (a == a3_s)) return wd_s;
`endif
      return mem_m[a];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
      wcnt_m = 0;
   endfunction

   task automatic expect_now(input string nm);
      q_rd1.push_back(model_read(a1_s));
      q_rd2.push_back(model_read(a2_s));
      q_wc.push_back(wcnt_m);
      q_nm.push_back(nm);
      ->sample_ev;
      #2;
   endtask

   task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                        input logic [31:0] wd, input logic we, input logic [31:0] pc);
      @(negedge clk_s);
      a1_s = a1; a2_s = a2; a3_s = a3; wd_s = wd; we_s = we; pc_s = pc;
   endtask

   // Commit rule applied to the values present at the rising edge.
   task automatic edge_commit();
      @(posedge clk_s);
      if (reset_s && we_s && (a3_s != 5'd0)) begin
         mem_m[a3_s] = wd_s;
         wcnt_m = (wcnt_m + 1) % (1 << CW);
      end
   endtask

   // Monitor: pops one expectation per sample event and compares it with the DUT outputs.
   initial begin
      logic [31:0] e1, e2;
      int ew;
      string nm;
      forever begin
         @(sample_ev);
         #1;
         checks++;
         if (q_nm.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got sample with no expectation, required one queued");
         end else begin
            e1 = q_rd1.pop_front(); e2 = q_rd2.pop_front(); ew = q_wc.pop_front(); nm = q_nm.pop_front();
            if (rd1_s !== e1) begin
               failures++;
               $display("FAIL %s rd1: got %h expected %h", nm, rd1_s, e1);
            end
            checks++;
            if (rd2_s !== e2) begin
               failures++;
               $display("FAIL %s rd2: got %h expected %h", nm, rd2_s, e2);
            end
            checks++;
            if (wcnt_s !== CW'(ew)) begin
               failures++;
               $display("FAIL %s wcnt: got %0d expected %0d", nm, wcnt_s, ew);
            end
         end
      end
   end

   initial begin
      logic [4:0] ra1, ra2, ra3;
      model_clear();
      #3;
      // reset held: reads and counter are zero
      drive(5'd5, 5'd31, 5'd0, 32'd0, 1'b0, 32'd0);
      expect_now("reset_hold");
      edge_commit();
      @(negedge clk_s);
      reset_s = 1'b1;

      // write $5, then pulse reset mid-cycle
      drive(5'd0, 5'd0, 5'd5, 32'h1234, 1'b1, 32'h0000_3000);
      edge_commit();
      drive(5'd5, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0000_3004);
      expect_now("pre_pulse");
      reset_s = 1'b0;
      model_clear();
      #1;
      expect_now("reset_pulse");

      // reset release coincident with an edge: that edge must not commit
      a1_s = 5'd7; a3_s = 5'd7; wd_s = 32'h77; we_s = 1'b1; pc_s = 32'h0000_3008;
      edge_commit();
      #1 reset_s = 1'b1;
      @(negedge clk_s);
      expect_now("coinc_no_commit");
      edge_commit();
      drive(5'd7, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0000_300c);
      expect_now("coinc_next_edge");

      // basic write/read
      drive(5'd0, 5'd0, 5'd8, 32'hDEADBEEF, 1'b1, 32'h0000_3000);
      edge_commit();
      drive(5'd8, 5'd8, 5'd0, 32'd0, 1'b0, 32'h0000_3004);
      expect_now("basic");

      // writes to $0 are discarded
      drive(5'd0, 5'd8, 5'd0, 32'hFFFFFFFF, 1'b1, 32'h0000_3008);
      edge_commit();
      drive(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0000_300c);
      expect_now("zero_reg");

      // same-cycle read/write hazard
      drive(5'd0, 5'd0, 5'd9, 32'h11, 1'b1, 32'h0000_3010);
      edge_commit();
      drive(5'd9, 5'd9, 5'd9, 32'h22, 1'b1, 32'h0000_3014);
      expect_now("hazard_pre");
      edge_commit();
      drive(5'd9, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0000_3018);
      expect_now("hazard_post");

      // dual-port independence, WE low leaves $3 alone
      drive(5'd0, 5'd0, 5'd3, 32'hA, 1'b1, 32'h0000_301c);
      edge_commit();
      drive(5'd0, 5'd0, 5'd4, 32'hB, 1'b1, 32'h0000_3020);
      edge_commit();
      drive(5'd3, 5'd4, 5'd3, 32'h0, 1'b0, 32'h0000_3024);
      expect_now("dual_read");
      edge_commit();
      @(negedge clk_s);
      expect_now("dual_we0");

      // randomized traffic with occasional mid-cycle reset pulses
      for (int n = 0; n < 400; n++) begin
         ra1 = 5'($urandom_range(0, 31));
         ra2 = 5'($urandom_range(0, 31));
         ra3 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         if ($urandom_range(0, 3) == 0) ra1 = ra3;
         if ($urandom_range(0, 3) == 0) ra2 = ra3;
         drive(ra1, ra2, ra3, $urandom, 1'($urandom_range(0, 1)), 32'h0000_4000 + 32'(n * 4));
         expect_now("rand");
         if ($urandom_range(0, 39) == 0) begin
            reset_s = 1'b0;
            model_clear();
            #1;
            expect_now("rand_reset");
            reset_s = 1'b1;
         end
         edge_commit();
      end

      @(negedge clk_s);
      checks++;
      if (q_nm.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending entries, required 0", q_nm.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/grf_regfile.md
Name: grf_regfile

Overview:
- 32-entry general register file sitting directly upstream of the ALU in the single-cycle MIPS datapath.
- RD1 drives ALU input A; RD2 drives ALU input B, either directly or through the immediate mux.
- Written at the clock edge from the WB mux (ALU Result, DM read data, or PC+4).
- Also provides a committed-write counter and a simulation write trace for comparison against the reference simulator.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- A1  input  ADDR_W  read address port 1 (rs).
- A2  input  ADDR_W  read address port 2 (rt).
- A3  input  ADDR_W  write address (rd/rt/31, chosen upstream).
- WD  input  DATA_W  write data.
- WE  input  1  write enable (RegWrite).
- PC  input  32  PC of the instruction currently writing; trace only.
- RD1  output  DATA_W  read data for A1; feeds ALU A.
- RD2  output  DATA_W  read data for A2; feeds ALU B / DM write data.
- wcnt  output  CNT_W  number of committed writes since reset.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits. Register 0 is hardwired to zero.
- Reset: while reset==0, all registers and wcnt clear to 0 immediately, with no clock needed. Consequently RD1 and RD2 read 0.
- Reads: combinational, zero latency. RD1 = reg[A1] and RD2 = reg[A2]. If A1==0 then RD1=0; the same rule applies to RD2, regardless of any stored or bypassed value.
- Write commit: on the rising edge of clk, a write commits when reset==1, WE==1 and A3!=0. The commit sets reg[A3]<=WD. The new value is visible on reads after that edge.
- Writes to $0:
  - Discarded: no state change, and wcnt does not increment.
  - Trace still prints, with the value shown as 0.
- wcnt:
  - Increments by 1 on each committed write.
  - Wraps from 2**CNT_W-1 to 0 with no flag.
- Same-edge read/write of the same address (no bypass): the read returns the old value before the edge.
- Reset mid-operation:
  - An edge with reset==0 commits nothing.
  - Reset asserted between edges clears everything asynchronously, including a value written one edge earlier.
  - Reset deasserting coincident with a rising edge: that edge does not commit. The first commit can occur on the next edge.
- X handling: WE==X is treated as a simulation error. The block is not required to protect against it.
- Simulation trace (non-synthesisable, behind translate_off):
  - On every edge with reset==1 and WE==1, print "@%h: $%d <= %h" with PC, A3 and WD. For A3==0, WD is shown as 0.
  - Format is exactly this, with no leading text.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined: internal write-to-read forwarding is enabled.
  - If WE==1, A3!=0 and A1==A3, then RD1=WD combinationally in the same cycle. The same rule applies to RD2 with A2.
  - The $0 rule still has priority.
  - Used when WB and decode overlap; a later pipelined revision relies on this.
- Undefined: reads return stored contents only, per the rules above.
- Register state, wcnt and trace are identical in both builds.

Test Plan:
- Reset: hold reset=0, drive A1=5, A2=31 -> RD1=0, RD2=0, wcnt=0. Pulse reset=0 mid-cycle after writing $5=32'h1234 -> RD1 returns to 0 before the next edge.
- Basic write/read: WE=1, A3=8, WD=32'hDEADBEEF, PC=32'h00003000, one edge -> A1=8 gives RD1=32'hDEADBEEF. Trace prints "@00003000: $ 8 <= deadbeef". wcnt=1.
- $0 protection: WE=1, A3=0, WD=32'hFFFFFFFF, one edge -> A1=0 gives RD1=0 and wcnt unchanged. Trace line shows "<= 00000000".
- Same-cycle hazard: $9=32'h11; WE=1, A3=9, WD=32'h22, A1=9 before the edge -> without GRF_BYPASS_EN RD1=32'h11, with it RD1=32'h22. Both builds give RD1=32'h22 after the edge.
- Dual-port independence: write $3=32'hA, then $4=32'hB; set A1=3, A2=4 -> RD1=32'hA, RD2=32'hB. WE=0 with A3=3, WD=32'h0 -> $3 unchanged and wcnt=2.
- Reset/edge coincidence: WE=1, A3=7, WD=32'h77; release reset on the same rising edge -> $7=0. On the next edge, $7=32'h77 and wcnt=1.
